// File: rtl/neptuno_joyscan.sv
// Serial joystick scanner for a 74HC165-style chain; presents a frame-coherent active-low button vector.
// Optional JOYSCAN_DEBOUNCE_EN: commit only when two consecutive frames agree.
module neptuno_joyscan #(
  parameter int NUM_JOYS     = 2,
  parameter int BITS_PER_JOY = 8,
  parameter int CLK_DIV      = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             joy_data_i,
  output logic                             joy_clk_o,
  output logic                             joy_load_o,
  output logic [NUM_JOYS*BITS_PER_JOY-1:0] joys_o,
  output logic                             frame_done_o,
  output logic                             changed_o
);

  localparam int N    = NUM_JOYS * BITS_PER_JOY;
  localparam int S    = N + 3;
  localparam int HALF = CLK_DIV / 2;
  localparam int DW   = $clog2(CLK_DIV);
  localparam int SW   = $clog2(S);
  localparam int IW   = $clog2(N);
  localparam int BW   = $clog2(BITS_PER_JOY);

  if ((CLK_DIV % 2) != 0 || CLK_DIV < 4) begin : g_bad_div
    $error("neptuno_joyscan: CLK_DIV must be even and >= 4");
  end
  if (NUM_JOYS < 1 || NUM_JOYS > 4 || BITS_PER_JOY < 4 || BITS_PER_JOY > 12) begin : g_bad_size
    $error("neptuno_joyscan: NUM_JOYS must be 1..4 and BITS_PER_JOY 4..12");
  end

  typedef enum logic [1:0] {PH_LOAD, PH_SETTLE, PH_SHIFT, PH_GAP} phase_t;

  phase_t          phase_q, phase_d;
  logic [DW-1:0]   div_q, div_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    shadow_q, shadow_d;
  logic [N-1:0]    joys_q;
  logic [1:0]      sync_q;
  logic            joy_clk_q, joy_load_q, frame_done_q, changed_q;
  logic            sample_en, last_sample;
`ifdef JOYSCAN_DEBOUNCE_EN
  logic [N-1:0]    last_q;
`endif

  // ptr walks each joystick MSB first: B-1 .. 0, then jumps to the next joystick's MSB
  always_comb begin
    div_d       = div_q + 1'b1;
    slot_d      = slot_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    ptr_d       = ptr_q;
    shadow_d    = shadow_q;
    sample_en   = (phase_q == PH_SHIFT) && (div_q == DW'(HALF - 1));
    last_sample = sample_en && (slot_q == SW'(S - 2));

    if (div_q == DW'(CLK_DIV - 1)) begin
      div_d  = '0;
      slot_d = (slot_q == SW'(S - 1)) ? '0 : slot_q + 1'b1;
      case (phase_q)
        PH_LOAD:   phase_d = PH_SETTLE;
        PH_SETTLE: phase_d = PH_SHIFT;
        PH_SHIFT:  if (slot_q == SW'(S - 2)) phase_d = PH_GAP;
        default:   phase_d = PH_LOAD;
      endcase
    end

    if (phase_q == PH_LOAD) begin
      bit_cnt_d = BW'(BITS_PER_JOY - 1);
      ptr_d     = IW'(BITS_PER_JOY - 1);
    end else if (sample_en) begin
      shadow_d[ptr_q] = sync_q[1];
      if (bit_cnt_q == '0) begin
        bit_cnt_d = BW'(BITS_PER_JOY - 1);
        ptr_d     = ptr_q + IW'(2 * BITS_PER_JOY - 1);
      end else begin
        bit_cnt_d = bit_cnt_q - 1'b1;
        ptr_d     = ptr_q - 1'b1;
      end
    end
  end

  // Pin outputs are registered from next-state so they line up with div/slot without glitches
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q        <= '0;
      slot_q       <= '0;
      phase_q      <= PH_LOAD;
      bit_cnt_q    <= BW'(BITS_PER_JOY - 1);
      ptr_q        <= IW'(BITS_PER_JOY - 1);
      shadow_q     <= '1;
      sync_q       <= '1;
      joy_clk_q    <= 1'b0;
      joy_load_q   <= 1'b1;
      joys_q       <= '1;
      frame_done_q <= 1'b0;
      changed_q    <= 1'b0;
`ifdef JOYSCAN_DEBOUNCE_EN
      last_q       <= '1;
`endif
    end else begin
      div_q        <= div_d;
      slot_q       <= slot_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      ptr_q        <= ptr_d;
      shadow_q     <= shadow_d;
      sync_q       <= {sync_q[0], joy_data_i};
      joy_clk_q    <= (div_d >= DW'(HALF));
      joy_load_q   <= (phase_d != PH_LOAD);
      frame_done_q <= last_sample;
      changed_q    <= 1'b0;
`ifdef JOYSCAN_DEBOUNCE_EN
      if (last_sample) begin
        last_q <= shadow_d;
        if (shadow_d == last_q) begin
          joys_q    <= shadow_d;
          changed_q <= (shadow_d != joys_q);
        end
      end
`else
      if (last_sample) begin
        joys_q    <= shadow_d;
        changed_q <= (shadow_d != joys_q);
      end
`endif
    end
  end

  assign joy_clk_o    = joy_clk_q;
  assign joy_load_o   = joy_load_q;
  assign joys_o       = joys_q;
  assign frame_done_o = frame_done_q;
  assign changed_o    = changed_q;

endmodule
